// File: rtl/mouse_packet_tracker.sv
// PS/2 mouse packet tracker: assembles 3-byte packets, integrates motion into a
// clamped screen cursor position and reports button levels and click/packet pulses.
module mouse_packet_tracker #(
    parameter int X_MAX       = 639,
    parameter int Y_MAX       = 479,
    parameter int TIMEOUT_CYC = 200000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] ps2_byte,
    input  logic       ps2_byte_valid,
    output logic [9:0] MOUSE_X_POS,
    output logic [9:0] MOUSE_Y_POS,
    output logic       mouse_left,
    output logic       mouse_right,
    output logic       left_click,
    output logic       pkt_done
);

    // state   | meaning
    // WAIT_B0 | hunting for a status byte (bit3 set)
    // WAIT_B1 | status latched, waiting for dx byte
    // WAIT_B2 | dx latched, waiting for dy byte
    // COMMIT  | full packet held, outputs update on the edge leaving this state
    typedef enum logic [1:0] {WAIT_B0, WAIT_B1, WAIT_B2, COMMIT} state_t;

    localparam int TW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT_CYC - 1);
    localparam logic signed [11:0] X_MAX_S = 12'(X_MAX);
    localparam logic signed [11:0] Y_MAX_S = 12'(Y_MAX);

    state_t           state;
    logic [7:0]       status_q;
    logic [7:0]       dx_q;
    logic [7:0]       dy_q;
    logic [TW-1:0]    tmr;

    logic             timeout_hit;
    logic signed [11:0] dx_s;
    logic signed [11:0] dy_s;
    logic signed [11:0] sum_x;
    logic signed [11:0] sum_y;
    logic [9:0]       next_x;
    logic [9:0]       next_y;

    function automatic logic [9:0] clamp(input logic signed [11:0] v,
                                         input logic signed [11:0] max);
        logic [9:0] r;
        if (v < 12'sd0)
            r = 10'd0;
        else if (v > max)
            r = max[9:0];
        else
            r = v[9:0];
        return r;
    endfunction

    // Timer runs down from load value; terminal count ends a stalled packet.
    assign timeout_hit = ((state == WAIT_B1) || (state == WAIT_B2)) && (tmr == '0);

    assign dx_s  = {{3{status_q[4]}}, status_q[4], dx_q};
    assign dy_s  = {{3{status_q[5]}}, status_q[5], dy_q};
    assign sum_x = $signed({2'b00, MOUSE_X_POS}) + dx_s;
    assign sum_y = $signed({2'b00, MOUSE_Y_POS}) - dy_s;
    assign next_x = status_q[6] ? MOUSE_X_POS : clamp(sum_x, X_MAX_S);
    assign next_y = status_q[7] ? MOUSE_Y_POS : clamp(sum_y, Y_MAX_S);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= WAIT_B0;
            tmr         <= '0;
            status_q    <= 8'h00;
            dx_q        <= 8'h00;
            dy_q        <= 8'h00;
            MOUSE_X_POS <= 10'd320;
            MOUSE_Y_POS <= 10'd240;
            mouse_left  <= 1'b0;
            mouse_right <= 1'b0;
            left_click  <= 1'b0;
            pkt_done    <= 1'b0;
        end else begin
            left_click <= 1'b0;
            pkt_done   <= 1'b0;
            case (state)
                WAIT_B0: begin
                    if (ps2_byte_valid && ps2_byte[3]) begin
                        status_q <= ps2_byte;
                        tmr      <= TMR_LOAD;
                        state    <= WAIT_B1;
                    end
                end
                WAIT_B1: begin
                    if (timeout_hit) begin
                        state <= WAIT_B0;
                    end else if (ps2_byte_valid) begin
                        dx_q  <= ps2_byte;
                        tmr   <= TMR_LOAD;
                        state <= WAIT_B2;
                    end else begin
                        tmr <= tmr - TW'(1);
                    end
                end
                WAIT_B2: begin
                    if (timeout_hit) begin
                        state <= WAIT_B0;
                    end else if (ps2_byte_valid) begin
                        dy_q  <= ps2_byte;
                        tmr   <= TMR_LOAD;
                        state <= COMMIT;
                    end else begin
                        tmr <= tmr - TW'(1);
                    end
                end
                COMMIT: begin
                    MOUSE_X_POS <= next_x;
                    MOUSE_Y_POS <= next_y;
                    mouse_left  <= status_q[0];
                    mouse_right <= status_q[1];
                    left_click  <= status_q[0] & ~mouse_left;
                    pkt_done    <= 1'b1;
                    state       <= WAIT_B0;
                end
                default: state <= WAIT_B0;
            endcase
        end
    end

endmodule

// File: tb/tb_mouse_packet_tracker.sv
// Bench for mouse_packet_tracker: directed vector table, corner-case sequences and
// randomized traffic against a queue-based packet model.
module tb_mouse_packet_tracker;

    localparam int T  = 16;
    localparam int XM = 639;
    localparam int YM = 479;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] ps2_byte = 8'h00;
    logic       ps2_byte_valid = 1'b0;
    logic [9:0] MOUSE_X_POS;
    logic [9:0] MOUSE_Y_POS;
    logic       mouse_left;
    logic       mouse_right;
    logic       left_click;
    logic       pkt_done;

    mouse_packet_tracker #(.X_MAX(XM), .Y_MAX(YM), .TIMEOUT_CYC(T)) dut (
        .clk(clk), .rst(rst), .ps2_byte(ps2_byte), .ps2_byte_valid(ps2_byte_valid),
        .MOUSE_X_POS(MOUSE_X_POS), .MOUSE_Y_POS(MOUSE_Y_POS),
        .mouse_left(mouse_left), .mouse_right(mouse_right),
        .left_click(left_click), .pkt_done(pkt_done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;

    // reference model: packet bytes collected so far plus commit-pending flag
    logic [7:0] q[$];
    bit pend = 0;
    int since = 0;
    int m_x = 320, m_y = 240;
    bit m_l = 0, m_r = 0, m_click = 0, m_done = 0;

    function automatic int clampi(input int v, input int max);
        if (v < 0) return 0;
        if (v > max) return max;
        return v;
    endfunction

    task automatic model_step(input bit r, input bit v, input logic [7:0] b);
        int dx, dy;
        if (r) begin
            q.delete(); pend = 0; since = 0;
            m_x = 320; m_y = 240; m_l = 0; m_r = 0; m_click = 0; m_done = 0;
        end else begin
            m_click = 0; m_done = 0;
            if (pend) begin
                dx = int'(q[1]) - (q[0][4] ? 256 : 0);
                dy = int'(q[2]) - (q[0][5] ? 256 : 0);
                if (!q[0][6]) m_x = clampi(m_x + dx, XM);
                if (!q[0][7]) m_y = clampi(m_y - dy, YM);
                m_click = q[0][0] && !m_l;
                m_l = q[0][0];
                m_r = q[0][1];
                m_done = 1;
                pend = 0;
                q.delete();
            end else if (q.size() > 0 && since == T - 1) begin
                q.delete();
            end else if (v) begin
                if (q.size() > 0 || b[3]) begin
                    q.push_back(b);
                    since = 0;
                    if (q.size() == 3) pend = 1;
                end
            end else if (q.size() > 0) begin
                since++;
            end
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            if (bad <= 40) $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    task automatic cycle(input bit r, input bit v, input logic [7:0] b, input bit cmp);
        rst = r; ps2_byte_valid = v; ps2_byte = b;
        @(posedge clk);
        model_step(r, v, b);
        #1;
        if (pkt_done) done_cnt++;
        if (cmp) begin
            chk("x", int'(MOUSE_X_POS), m_x);
            chk("y", int'(MOUSE_Y_POS), m_y);
            chk("left", int'(mouse_left), int'(m_l));
            chk("right", int'(mouse_right), int'(m_r));
            chk("click", int'(left_click), int'(m_click));
            chk("done", int'(pkt_done), int'(m_done));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 8'h00, 1);
    endtask

    task automatic send(input logic [7:0] b);
        cycle(0, 1, b, 1);
    endtask

    task automatic do_reset();
        cycle(1, 0, 8'h00, 1);
        cycle(1, 0, 8'h00, 1);
    endtask

    typedef struct {
        bit r; bit v; logic [7:0] b;
        int x; int y; bit l; bit c; bit d;
    } vec_t;
    vec_t tbl[24];

    initial begin
        int dc;
        tbl[0]  = '{1, 0, 8'h00, 320, 240, 0, 0, 0};
        tbl[1]  = '{0, 1, 8'h09, 320, 240, 0, 0, 0};
        tbl[2]  = '{0, 1, 8'h0A, 320, 240, 0, 0, 0};
        tbl[3]  = '{0, 1, 8'h05, 320, 240, 0, 0, 0};
        tbl[4]  = '{0, 0, 8'h00, 330, 235, 1, 1, 1};
        tbl[5]  = '{0, 0, 8'h00, 330, 235, 1, 0, 0};
        tbl[6]  = '{0, 1, 8'h00, 330, 235, 1, 0, 0};
        tbl[7]  = '{0, 1, 8'h08, 330, 235, 1, 0, 0};
        tbl[8]  = '{0, 1, 8'h00, 330, 235, 1, 0, 0};
        tbl[9]  = '{0, 1, 8'h00, 330, 235, 1, 0, 0};
        tbl[10] = '{0, 0, 8'h00, 330, 235, 0, 0, 1};
        tbl[11] = '{0, 0, 8'h00, 330, 235, 0, 0, 0};
        tbl[12] = '{0, 1, 8'h09, 330, 235, 0, 0, 0};
        tbl[13] = '{0, 1, 8'h0A, 330, 235, 0, 0, 0};
        tbl[14] = '{0, 1, 8'h05, 330, 235, 0, 0, 0};
        tbl[15] = '{1, 0, 8'h00, 320, 240, 0, 0, 0};
        tbl[16] = '{0, 0, 8'h00, 320, 240, 0, 0, 0};
        tbl[17] = '{0, 1, 8'h09, 320, 240, 0, 0, 0};
        tbl[18] = '{0, 1, 8'h01, 320, 240, 0, 0, 0};
        tbl[19] = '{0, 1, 8'h00, 320, 240, 0, 0, 0};
        tbl[20] = '{0, 1, 8'h09, 321, 240, 1, 1, 1};
        tbl[21] = '{0, 1, 8'h01, 321, 240, 1, 0, 0};
        tbl[22] = '{0, 1, 8'h00, 321, 240, 1, 0, 0};
        tbl[23] = '{0, 0, 8'h00, 321, 240, 1, 0, 0};

        cycle(1, 0, 8'h00, 0);
        for (int i = 0; i < 24; i++) begin
            cycle(tbl[i].r, tbl[i].v, tbl[i].b, 0);
            chk($sformatf("vec%0d_x", i), int'(MOUSE_X_POS), tbl[i].x);
            chk($sformatf("vec%0d_y", i), int'(MOUSE_Y_POS), tbl[i].y);
            chk($sformatf("vec%0d_left", i), int'(mouse_left), int'(tbl[i].l));
            chk($sformatf("vec%0d_click", i), int'(left_click), int'(tbl[i].c));
            chk($sformatf("vec%0d_done", i), int'(pkt_done), int'(tbl[i].d));
        end

        // dx = -256 twice: 320 -> 64 -> clamp 0
        do_reset();
        send(8'h18); send(8'h00); send(8'h00); idle(1);
        chk("neg_dx_x", int'(MOUSE_X_POS), 64);
        chk("neg_dx_y", int'(MOUSE_Y_POS), 240);
        send(8'h18); send(8'h00); send(8'h00); idle(1);
        chk("clamp_x_lo", int'(MOUSE_X_POS), 0);

        // +255 both axes twice: X clamps at X_MAX, Y clamps at 0
        do_reset();
        send(8'h08); send(8'hFF); send(8'hFF); idle(1);
        chk("pos_dx_x", int'(MOUSE_X_POS), 575);
        chk("clamp_y_lo", int'(MOUSE_Y_POS), 0);
        send(8'h08); send(8'hFF); send(8'hFF); idle(1);
        chk("clamp_x_hi", int'(MOUSE_X_POS), XM);
        // dy = -256 moves cursor down: 0 -> 256 -> clamp Y_MAX
        send(8'h28); send(8'h00); send(8'h00); idle(1);
        chk("neg_dy_y", int'(MOUSE_Y_POS), 256);
        send(8'h28); send(8'h00); send(8'h00); idle(1);
        chk("clamp_y_hi", int'(MOUSE_Y_POS), YM);

        // timeout drops partial packet
        do_reset();
        send(8'h08); send(8'h10); idle(T);
        send(8'h08); send(8'h01); send(8'h00); idle(1);
        chk("timeout_x", int'(MOUSE_X_POS), 321);

        // last byte one cycle before expiry is still accepted
        do_reset();
        send(8'h08); send(8'h10); idle(T - 2); send(8'h00); idle(1);
        chk("pre_timeout_x", int'(MOUSE_X_POS), 336);
        // byte landing on the expiry cycle is discarded
        dc = done_cnt;
        send(8'h08); send(8'h10); idle(T - 1); send(8'h00); send(8'h00); idle(3);
        chk("expiry_x", int'(MOUSE_X_POS), 336);
        chk("expiry_no_done", done_cnt - dc, 0);

        // X overflow holds X, Y still moves; reset mid-packet
        do_reset();
        send(8'h48); send(8'h7F); send(8'h7F); idle(1);
        chk("ovf_x", int'(MOUSE_X_POS), 320);
        chk("ovf_y", int'(MOUSE_Y_POS), 113);
        dc = done_cnt;
        send(8'h08); send(8'h05); cycle(1, 0, 8'h00, 1);
        send(8'h10); send(8'h00); idle(4);
        chk("rst_mid_x", int'(MOUSE_X_POS), 320);
        chk("rst_mid_y", int'(MOUSE_Y_POS), 240);
        chk("rst_mid_no_done", done_cnt - dc, 0);

        // randomized traffic with varying byte density to hit timeouts
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            int pct;
            bit r, v;
            case ((i / 200) % 3)
                0: pct = 90;
                1: pct = 50;
                default: pct = 5;
            endcase
            r = ($urandom_range(0, 299) == 0);
            v = ($urandom_range(0, 99) < pct);
            cycle(r, v, 8'($urandom), 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
